// File: rtl/bt656_pkg.sv
// Shared constants, XY-word helper and parser state type for the
// Avalon-ST to BT.656 625-line transmitter.
package bt656_pkg;

    localparam int LINE_BYTES   = 1728;
    localparam int BLANK_BYTES  = 280;
    localparam int ACTIVE_BYTES = 1440;
    localparam int LINES        = 625;
    localparam int FIELD_PIXELS = 207360;
    localparam int EAV_BYTES    = 4;

    // Horizontal landmarks, sized to the 11-bit h counter
    localparam logic [10:0] H_LAST    = 11'(LINE_BYTES - 1);
    localparam logic [10:0] H_SAV     = 11'(EAV_BYTES + BLANK_BYTES);
    localparam logic [10:0] H_ACTIVE  = 11'(LINE_BYTES - ACTIVE_BYTES);
    localparam logic [10:0] H_FIRST_Y = 11'(LINE_BYTES - ACTIVE_BYTES + 1);

    // Line landmarks, sized to the 10-bit line counter
    localparam logic [9:0] LINE_FIRST   = 10'd1;
    localparam logic [9:0] LINE_LAST    = 10'(LINES);
    localparam logic [9:0] F1_FIRST     = 10'd313;
    localparam logic [9:0] V_TOP_LAST   = 10'd22;
    localparam logic [9:0] V_MID_FIRST  = 10'd311;
    localparam logic [9:0] V_MID_LAST   = 10'd335;
    localparam logic [9:0] V_BOT_FIRST  = 10'd624;
    localparam logic [9:0] FIELD0_START = 10'd23;
    localparam logic [9:0] FIELD1_START = 10'd336;

    localparam logic [17:0] FIELD_LAST_PIX = 18'(FIELD_PIXELS - 1);

    localparam logic [3:0] AST_TYPE_VIDEO = 4'h0;
    localparam logic [3:0] AST_TYPE_CTRL  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CTRL       = 3'd1,
        ST_WAIT_FIELD = 3'd2,
        ST_VIDEO      = 3'd3,
        ST_DRAIN      = 3'd4,
        ST_FLUSH      = 3'd5
    } parser_state_e;

    function automatic logic [7:0] bt656_xy(input logic f, input logic v, input logic h);
        bt656_xy = {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

endpackage

// File: rtl/bt656_timing_gen.sv
// Free-running 625-line BT.656 raster counters with F/V flags and
// per-byte region decode for the current counter position.
module bt656_timing_gen
    import bt656_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [10:0] o_h,
    output logic        o_f,
    output logic        o_v,
    output logic        o_eav,
    output logic        o_sav,
    output logic        o_blank,
    output logic        o_active,
    output logic        o_y_slot,
    output logic        o_field_start
);

    logic [10:0] r_h;
    logic [9:0]  r_line;
    logic        w_f;
    logic        w_v;
    logic        w_active;
    logic        w_y_slot;

    // Raster position: h wraps every line, line wraps every frame
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_h    <= 11'd0;
            r_line <= LINE_FIRST;
        end else if (r_h == H_LAST) begin
            r_h    <= 11'd0;
            r_line <= (r_line == LINE_LAST) ? LINE_FIRST : r_line + 10'd1;
        end else begin
            r_h    <= r_h + 11'd1;
        end
    end

    assign w_f      = (r_line >= F1_FIRST);
    assign w_v      = (r_line <= V_TOP_LAST)
                   || ((r_line >= V_MID_FIRST) && (r_line <= V_MID_LAST))
                   || (r_line >= V_BOT_FIRST);
    assign w_active = (r_h >= H_ACTIVE);
    assign w_y_slot = w_active && r_h[0] && !w_v;

    assign o_h           = r_h;
    assign o_f           = w_f;
    assign o_v           = w_v;
    assign o_eav         = (r_h < 11'd4);
    assign o_sav         = (r_h >= H_SAV) && (r_h < H_ACTIVE);
    assign o_blank       = (r_h >= 11'd4) && (r_h < H_SAV);
    assign o_active      = w_active;
    assign o_y_slot      = w_y_slot;
    assign o_field_start = w_y_slot && (r_h == H_FIRST_Y)
                        && ((r_line == FIELD0_START) || (r_line == FIELD1_START));

endmodule

// File: rtl/ast_to_bt656.sv
// Avalon-ST video sink to BT.656 PAL byte stream: packet parser feeding
// luma into a free-running raster, with a registered output byte.
module ast_to_bt656
    import bt656_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] CHROMA_FILL = 8'h80,
    parameter logic [DATA_WIDTH-1:0] BLACK_Y     = 8'h10
) (
    input  logic                  bt_clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] ast_data,
    input  logic                  ast_valid,
    input  logic                  ast_startofpacket,
    input  logic                  ast_endofpacket,
    output logic                  ast_ready,
    output logic [DATA_WIDTH-1:0] bt_data,
    output logic                  bt_field,
    output logic                  bt_vblank,
    output logic                  bt_underflow,
    output logic                  bt_format_err
);

    // 8-bit code words scaled into the MSBs for wider buses
    localparam int                    SH       = DATA_WIDTH - 8;
    localparam logic [DATA_WIDTH-1:0] W_ONES   = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] W_ZERO   = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] BLANK_CB = DATA_WIDTH'(8'h80) << SH;
    localparam logic [DATA_WIDTH-1:0] BLANK_Y  = DATA_WIDTH'(8'h10) << SH;
    localparam logic [DATA_WIDTH-1:0] Y_MIN    = DATA_WIDTH'(1) << SH;
    localparam logic [DATA_WIDTH-1:0] Y_MAX    = ~Y_MIN;

    logic [10:0]           w_h;
    logic                  w_f, w_v, w_eav, w_sav, w_blank, w_active;
    logic                  w_y_slot, w_field_start;
    parser_state_e         r_state, w_state_nxt;
    logic [17:0]           r_pix_cnt, w_pix_nxt, w_cnt_base;
    logic                  w_ready, w_beat, w_in_video, w_last_slot;
    logic                  w_set_uf, w_set_fe;
    logic [DATA_WIDTH-1:0] w_y_byte, w_byte, r_bt_data;
    logic                  r_field, r_vblank, r_underflow, r_format_err;

    function automatic logic [DATA_WIDTH-1:0] clamp_y(input logic [DATA_WIDTH-1:0] y);
        if (y < Y_MIN)      return Y_MIN;
        else if (y > Y_MAX) return Y_MAX;
        else                return y;
    endfunction

    function automatic parser_state_e header_next(input logic [3:0] typ, input logic eop);
        if (typ == AST_TYPE_VIDEO) return ST_WAIT_FIELD;
        else if (eop)              return ST_IDLE;
        else                       return ST_CTRL;
    endfunction

    bt656_timing_gen u_timing (
        .i_clk         (bt_clock),
        .i_reset       (reset),
        .o_h           (w_h),
        .o_f           (w_f),
        .o_v           (w_v),
        .o_eav         (w_eav),
        .o_sav         (w_sav),
        .o_blank       (w_blank),
        .o_active      (w_active),
        .o_y_slot      (w_y_slot),
        .o_field_start (w_field_start)
    );

    // The first Y slot of a field is already a video slot, so WAIT_FIELD
    // opens the sink there and pixel 0 lands at h=289 of the first line.
    assign w_in_video  = (r_state == ST_VIDEO) || ((r_state == ST_WAIT_FIELD) && w_field_start);
    assign w_cnt_base  = (r_state == ST_WAIT_FIELD) ? 18'd0 : r_pix_cnt;
    assign w_last_slot = (w_cnt_base == FIELD_LAST_PIX);
    assign w_beat      = ast_valid && w_ready;

    // Sink ready: open whenever a beat can be consumed without stalling the raster
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE, ST_CTRL, ST_DRAIN: w_ready = 1'b1;
            ST_WAIT_FIELD:              w_ready = w_field_start;
            ST_VIDEO:                   w_ready = w_y_slot;
            ST_FLUSH:                   w_ready = 1'b0;
            default:                    w_ready = 1'b0;
        endcase
    end

    // Parser next state, pixel count, luma selection and sticky error events
    always_comb begin
        w_state_nxt = r_state;
        w_pix_nxt   = r_pix_cnt;
        w_y_byte    = BLACK_Y;
        w_set_uf    = 1'b0;
        w_set_fe    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // No packet on a visible line means the picture is black, not source video
                w_set_uf = w_y_slot;
                if (w_beat && ast_startofpacket) begin
                    w_state_nxt = header_next(ast_data[3:0], ast_endofpacket);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CTRL, ST_DRAIN: begin
                if (w_beat && ast_endofpacket) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_WAIT_FIELD, ST_VIDEO: begin
                if (w_in_video && w_y_slot) begin
                    w_pix_nxt = w_cnt_base + 18'd1;
                    if (!ast_valid) begin
                        w_set_uf    = 1'b1;
                        w_state_nxt = w_last_slot ? ST_DRAIN : ST_VIDEO;
                    end else if (ast_startofpacket) begin
                        w_set_fe    = 1'b1;
                        w_state_nxt = header_next(ast_data[3:0], ast_endofpacket);
                    end else begin
                        w_y_byte = clamp_y(ast_data);
                        if (w_last_slot) begin
                            w_set_fe    = !ast_endofpacket;
                            w_state_nxt = ast_endofpacket ? ST_IDLE : ST_DRAIN;
                        end else if (ast_endofpacket) begin
                            w_set_fe    = 1'b1;
                            w_state_nxt = ST_FLUSH;
                        end else begin
                            w_state_nxt = ST_VIDEO;
                        end
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_FLUSH: begin
                if (w_y_slot) begin
                    w_pix_nxt   = r_pix_cnt + 18'd1;
                    w_state_nxt = (r_pix_cnt == FIELD_LAST_PIX) ? ST_IDLE : ST_FLUSH;
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Parser state and field pixel counter
    always_ff @(posedge bt_clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pix_cnt <= 18'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pix_cnt <= w_pix_nxt;
        end
    end

    // Byte for the current raster position: timing codes, blanking or active video
    always_comb begin
        w_byte = BLANK_CB;
        if (w_eav || w_sav) begin
            case (w_h[1:0])
                2'd0:    w_byte = W_ONES;
                2'd1:    w_byte = W_ZERO;
                2'd2:    w_byte = W_ZERO;
                2'd3:    w_byte = DATA_WIDTH'(bt656_xy(w_f, w_v, w_eav)) << SH;
                default: w_byte = W_ZERO;
            endcase
        end else if (w_blank || (w_active && w_v)) begin
            w_byte = w_h[0] ? BLANK_Y : BLANK_CB;
        end else begin
            w_byte = w_h[0] ? w_y_byte : CHROMA_FILL;
        end
    end

    // Output register and sticky status flags
    always_ff @(posedge bt_clock or posedge reset) begin
        if (reset) begin
            r_bt_data    <= BLANK_CB;
            r_field      <= 1'b0;
            r_vblank     <= 1'b1;
            r_underflow  <= 1'b0;
            r_format_err <= 1'b0;
        end else begin
            r_bt_data    <= w_byte;
            r_field      <= w_f;
            r_vblank     <= w_v;
            r_underflow  <= r_underflow | w_set_uf;
            r_format_err <= r_format_err | w_set_fe;
        end
    end

    assign ast_ready     = w_ready;
    assign bt_data       = r_bt_data;
    assign bt_field      = r_field;
    assign bt_vblank     = r_vblank;
    assign bt_underflow  = r_underflow;
    assign bt_format_err = r_format_err;

endmodule
